// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receiver, 8 data bits LSB first, optional
// parity, one stop bit; flags good frames, parity errors and stop errors.
//
// Parameter:
//   PRESCALE    CLK cycles per bit (8, 16 or 32)
// Ports:
//   CLK         receive clock, PRESCALE x baud
//   RST         asynchronous active-low reset
//   RX_IN       serial line, idle high, synchronous to CLK
//   PAR_EN      frame carries a parity bit (captured at start detection)
//   PAR_TYP     0 = even, 1 = odd parity (captured at start detection)
//   P_DATA      last good data byte
//   Data_Valid  one-cycle pulse, good frame
//   Par_Err     one-cycle pulse, parity mismatch
//   Stp_Err     one-cycle pulse, stop bit sampled low
//   Busy        high whenever the FSM is not in IDLE
// Build option:
//   UART_RX_MAJORITY_VOTE_EN  bit value is the 2-of-3 majority of the
//                             samples at PRESCALE/2-1, PRESCALE/2 and
//                             PRESCALE/2+1 instead of a single mid sample.

module uart_rx_frame #(
    parameter int PRESCALE = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       Data_Valid,
    output logic       Par_Err,
    output logic       Stp_Err,
    output logic       Busy
);

    localparam int CW = $clog2(PRESCALE);

    localparam logic [CW-1:0] TICK_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] TICK_MID  = CW'(PRESCALE / 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0] edge_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          bit_val;
    logic          par_en_q;
    logic          par_typ_q;
    logic          par_bad;
    logic          start_det;
    logic          tick_last;
    logic          par_exp;
    logic          stop_bad;

    // The detecting edge is tick 0 of the start bit.
    assign start_det = (state == IDLE) && !RX_IN;
    assign tick_last = (edge_cnt == TICK_LAST);
    assign par_exp   = par_typ_q ? ~^shift_reg : ^shift_reg;
    assign stop_bad  = !bit_val;
    assign Busy      = (state != IDLE);

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (!RX_IN) begin
                    next_state = START;
                end
            end
            START: begin
                // A start bit that reads high at mid-bit is a glitch.
                if (tick_last) begin
                    next_state = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_last && (bit_cnt == 3'd7)) begin
                    next_state = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick_last) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (tick_last) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Edge counter: 0..PRESCALE-1 within every bit
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
        end else if (start_det) begin
            edge_cnt <= CW'(1);
        end else if ((state == IDLE) || tick_last) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + CW'(1);
        end
    end

    // ---------------------------------------------------------------
    // Bit sampler; bit_val is settled well before the bit's last tick
    // ---------------------------------------------------------------
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] TICK_PRE  = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] TICK_POST = CW'(PRESCALE / 2 + 1);

    logic s_pre;
    logic s_mid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s_pre   <= 1'b1;
            s_mid   <= 1'b1;
            bit_val <= 1'b1;
        end else if (Busy) begin
            if (edge_cnt == TICK_PRE) begin
                s_pre <= RX_IN;
            end
            if (edge_cnt == TICK_MID) begin
                s_mid <= RX_IN;
            end
            if (edge_cnt == TICK_POST) begin
                bit_val <= (s_pre & s_mid) |
                           (s_pre & RX_IN) |
                           (s_mid & RX_IN);
            end
        end
    end
`else
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_val <= 1'b1;
        end else if (Busy && (edge_cnt == TICK_MID)) begin
            bit_val <= RX_IN;
        end
    end
`endif

    // ---------------------------------------------------------------
    // Frame datapath
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad   <= 1'b0;
        end else if (start_det) begin
            bit_cnt   <= '0;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_bad   <= 1'b0;
        end else if (tick_last) begin
            if (state == DATA) begin
                // LSB arrives first, so shift in from the top.
                shift_reg <= {bit_val, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (state == PARITY) begin
                par_bad <= (bit_val != par_exp);
            end
        end
    end

    // ---------------------------------------------------------------
    // Result pulses, one cycle after the stop bit's last tick
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA     <= 8'h00;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            if ((state == STOP) && tick_last) begin
                Par_Err <= par_bad;
                Stp_Err <= stop_bad;
                if (!par_bad && !stop_bad) begin
                    Data_Valid <= 1'b1;
                    P_DATA     <= shift_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: randomized and directed frames against a frame-level
// reference model of uart_rx_frame.

module tb_uart_rx_frame;

    localparam int P = 8;

    logic       CLK     = 1'b0;
    logic       RST     = 1'b0;
    logic       RX_IN   = 1'b1;
    logic       PAR_EN  = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;
    logic       Busy;

    uart_rx_frame #(.PRESCALE(P)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic        dv;
        logic        pe;
        logic        se;
        logic [7:0]  data;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         n_cmp = 0;
    int         n_bad = 0;

    // Record every result pulse with the cycle it is seen in.
    always @(negedge CLK) begin
        ev_t m;
        if (Data_Valid || Par_Err || Stp_Err) begin
            m.cyc  = 32'(cyc);
            m.dv   = Data_Valid;
            m.pe   = Par_Err;
            m.se   = Stp_Err;
            m.data = P_DATA;
            obs_q.push_back(m);
        end
    end

    function automatic string fmt(ev_t e);
        return $sformatf("cyc=%0d dv=%b pe=%b se=%b data=%h",
                         e.cyc, e.dv, e.pe, e.se, e.data);
    endfunction

    // Drives one frame starting at the current negedge and returns at the
    // negedge right after the stop bit. Records the expected outcome.
    task automatic send_frame(input logic [7:0] b, input logic pe,
                              input logic pt, input logic bad_par,
                              input logic stop_bit);
        int   t0;
        logic pbit;
        ev_t  e;
        PAR_EN  = pe;
        PAR_TYP = pt;
        RX_IN   = 1'b0;
        t0      = cyc;
        repeat (P) @(negedge CLK);
        // Mode pins may wander once the frame has started.
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            RX_IN = b[i];
            repeat (P) @(negedge CLK);
        end
        pbit = (pt ? ~^b : ^b) ^ bad_par;
        if (pe) begin
            RX_IN = pbit;
            repeat (P) @(negedge CLK);
        end
        RX_IN = stop_bit;
        repeat (P) @(negedge CLK);
        e.cyc  = 32'(t0 + P * (pe ? 11 : 10));
        e.pe   = pe && bad_par;
        e.se   = !stop_bit;
        e.dv   = !e.pe && !e.se;
        if (e.dv) last_good = b;
        e.data = last_good;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        RST   = 1'b0;
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({P_DATA, Data_Valid, Par_Err, Stp_Err, Busy} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_hold: got data=%h dv=%b pe=%b se=%b busy=%b want all 0",
                     P_DATA, Data_Valid, Par_Err, Stp_Err, Busy);
        end
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({P_DATA, Data_Valid, Par_Err, Stp_Err, Busy} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_release: got data=%h dv=%b pe=%b se=%b busy=%b want all 0",
                     P_DATA, Data_Valid, Par_Err, Stp_Err, Busy);
        end
    endtask

    task automatic test_directed;
        ev_t e;
        ev_t o;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        n_cmp++;
        if (P_DATA !== 8'hA5) begin
            n_bad++;
            $display("FAIL directed_hold: got data=%h want a5", P_DATA);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL directed_count: got %0d pulses want %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL directed_event: got %s want %s", fmt(o), fmt(e));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_glitch;
        ev_t e;
        ev_t o;
        RX_IN = 1'b0;
        for (int r = 1; r <= 12; r++) begin
            @(negedge CLK);
            if (r == 3) RX_IN = 1'b1;
            n_cmp++;
            if (Busy !== (r <= 7)) begin
                n_bad++;
                $display("FAIL glitch_busy: cycle %0d got busy=%b want %b",
                         r, Busy, (r <= 7));
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL glitch_pulse: got %0d pulses want 0", obs_q.size());
        end
        obs_q.delete();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_bad++;
            $display("FAIL glitch_count: got %0d pulses want 1", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL glitch_event: got %s want %s", fmt(o), fmt(e));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        ev_t e;
        ev_t o;
        send_frame(8'h12, 1'b1, 1'($urandom), 1'b0, 1'b1);
        send_frame(8'h34, 1'b1, 1'($urandom), 1'b0, 1'b1);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        n_cmp++;
        if (obs_q.size() != 2) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d pulses want 2", obs_q.size());
        end else if (obs_q[1].cyc - obs_q[0].cyc != 32'(11 * P)) begin
            n_bad++;
            $display("FAIL b2b_gap: got %0d cycles want %0d",
                     obs_q[1].cyc - obs_q[0].cyc, 11 * P);
        end
        // Line stays low through the stop bit and into the next frame.
        send_frame(8'h9E, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h47, 1'b0, 1'b0, 1'b0, 1'b1);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL b2b_total: got %0d pulses want %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL b2b_event: got %s want %s", fmt(o), fmt(e));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_midframe;
        ev_t        e;
        ev_t        o;
        logic [7:0] b;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        exp_q.delete();
        obs_q.delete();
        b       = 8'($urandom);
        PAR_EN  = 1'b1;
        RX_IN   = 1'b0;
        repeat (P) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RX_IN = b[i];
            repeat (P) @(negedge CLK);
        end
        RX_IN = b[4];
        repeat (P / 2) @(negedge CLK);
        RST = 1'b0;
        #1;
        n_cmp++;
        if ({P_DATA, Data_Valid, Par_Err, Stp_Err, Busy} !== 12'h000) begin
            n_bad++;
            $display("FAIL midreset_outputs: got data=%h dv=%b pe=%b se=%b busy=%b want all 0",
                     P_DATA, Data_Valid, Par_Err, Stp_Err, Busy);
        end
        last_good = 8'h00;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        RST   = 1'b1;
        repeat (3 * P) @(negedge CLK);
        n_cmp++;
        if (obs_q.size() != 0 || Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_quiet: got %0d pulses busy=%b want 0 pulses busy=0",
                     obs_q.size(), Busy);
        end
        obs_q.delete();
        send_frame(8'($urandom), 1'b1, 1'($urandom), 1'b0, 1'b1);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_bad++;
            $display("FAIL midreset_count: got %0d pulses want 1", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL midreset_event: got %s want %s", fmt(o), fmt(e));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_random;
        ev_t e;
        ev_t o;
        int  gap;
        for (int n = 0; n < 24; n++) begin
            send_frame(8'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(3) == 0), ($urandom_range(3) != 0));
            gap = int'($urandom_range(3));
            if (gap > 0) begin
                RX_IN = 1'b1;
                repeat (gap) @(negedge CLK);
            end
        end
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL random_count: got %0d pulses want %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL random_event: got %s want %s", fmt(o), fmt(e));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
